// File: rtl/parity_frame_tx.sv
// Serial framer: 2-deep buffer of parity-tagged bytes sent as start, 8 data bits MSB first, parity, stop.
// tx_out is registered; the start bit appears two cycles after an accepting strobe into an idle block.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       asyn_rst,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow,
  output logic       parity_err
);
  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic [8:0] mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, perr_q;
  logic       pop, push, last_cyc;

  assign last_cyc = (cyc_q == LAST_CYC);
  // A full buffer still accepts a byte on the edge where the framer pops its head.
  assign push  = valid_in && ((cnt_q != 2'd2) || pop);
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE:    if (cnt_q != 2'd0) pop = 1'b1;
      START:   if (last_cyc) state_d = DATA;
      DATA:    if (last_cyc && bit_q == 3'd7) state_d = PARITY;
      PARITY:  if (last_cyc) state_d = STOP;
      STOP: begin
        if (last_cyc) begin
          if (cnt_q != 2'd0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d          = START;
      {data_d, par_d}  = mem_q[rd_ptr_q];
    end
    if (state_q != IDLE) begin
      cyc_d = last_cyc ? 8'd0 : cyc_q + 8'd1;
      if (state_q == DATA && last_cyc) bit_d = bit_q + 3'd1;
    end
    // Line value is computed from the next state so the register leads the FSM by nothing.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[3'd7 - bit_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_rst) begin
    if (!asyn_rst) begin
      state_q  <= IDLE;
      cyc_q    <= 8'd0;
      bit_q    <= 3'd0;
      data_q   <= 8'd0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      mem_q[0] <= 9'd0;
      mem_q[1] <= 9'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push) begin
        mem_q[wr_ptr_q] <= {data_in, parity_in};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      ovf_q  <= valid_in && !push;
      perr_q <= push && (parity_in != ^data_in);
    end
  end

  assign tx_out     = tx_q;
  assign busy       = (state_q != IDLE) || (cnt_q != 2'd0);
  assign frame_done = (state_q == STOP) && last_cyc;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: a line monitor decodes frames and pops a scoreboard of expected bytes.
module tb_parity_frame_tx;
  logic       clk = 1'b0;
  logic       asyn_rst;
  logic       valid_in, parity_in;
  logic [7:0] data_in;
  logic       tx_out, busy, frame_done, overflow, parity_err;
  logic       valid1, parity1;
  logic [7:0] data1;
  logic       tx1, busy1, done1, ovf1, perr1;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  logic [8:0] exp_q[$];
  logic       exp1_q[$];
  int         starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .asyn_rst(asyn_rst), .valid_in(valid_in), .data_in(data_in),
    .parity_in(parity_in), .tx_out(tx_out), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .parity_err(parity_err)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .asyn_rst(asyn_rst), .valid_in(valid1), .data_in(data1),
    .parity_in(parity1), .tx_out(tx1), .busy(busy1), .frame_done(done1),
    .overflow(ovf1), .parity_err(perr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic drop, output int n);
    valid_in  = 1'b1;
    data_in   = d;
    parity_in = p;
    n         = cyc;
    if (!drop) exp_q.push_back({d, p});
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 400;
    while ((busy !== 1'b0 || exp_q.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, budget > 0, 1);
  endtask

  // Frame decoder for the CLKS_PER_BIT=4 instance
  initial begin : mon
    logic [10:0] bits;
    logic [8:0]  e;
    logic        stable, aborted;
    int          t0;
    forever begin
      @(negedge clk);
      if (asyn_rst === 1'b1 && tx_out === 1'b0) begin
        t0 = cyc; stable = 1'b1; aborted = 1'b0; bits = '0;
        for (int b = 0; b < 11; b++) begin
          for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (asyn_rst !== 1'b1) aborted = 1'b1;
            if (c == 0) bits[10-b] = tx_out;
            else if (tx_out !== bits[10-b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          starts.push_back(t0);
          check("frame_done_at_stop_end", frame_done, 1);
          check("bit_hold_stable", stable, 1);
          check("scoreboard_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_bits", bits, {1'b0, e, 1'b1});
          end
        end
      end
    end
  end

  initial begin
    int   n, n1, n0;
    logic low_seen;
    logic b;
    logic [7:0] d1;
    asyn_rst = 1'b1; valid_in = 1'b0; data_in = 8'h00; parity_in = 1'b0;
    valid1 = 1'b0; data1 = 8'h00; parity1 = 1'b0;
    #1 asyn_rst = 1'b0;
    #3;
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", parity_err, 0);
    check("rst_tx1", tx1, 1);
    #19 asyn_rst = 1'b1;
    tick(); tick();

    // single byte 0xA5, good parity
    starts.delete();
    send(8'hA5, 1'b0, 1'b0, n);
    check("n1_tx_high", tx_out, 1);
    check("n1_busy", busy, 1);
    check("n1_perr_clear", parity_err, 0);
    goto(n + 2);
    check("n2_tx_low", tx_out, 0);
    goto(n + 45);
    check("n45_done", frame_done, 1);
    check("n45_busy", busy, 1);
    goto(n + 46);
    check("n46_done_low", frame_done, 0);
    check("n46_busy_low", busy, 0);
    check("n46_tx_idle", tx_out, 1);
    check("a5_start_offset", (starts.size() == 1) ? starts[0] - n : -1, 2);

    // bad parity still transmitted as supplied
    tick();
    send(8'h01, 1'b0, 1'b0, n);
    check("perr_pulse", parity_err, 1);
    tick();
    check("perr_one_cycle", parity_err, 0);
    wait_idle("perr_frame_idle");

    // overflow: fourth strobe dropped, rest back-to-back
    tick();
    starts.delete();
    n0 = ovf_cnt;
    send(8'h11, 1'b0, 1'b0, n1); tick();
    send(8'h22, 1'b0, 1'b0, n);  tick();
    send(8'h33, 1'b0, 1'b0, n);  tick();
    send(8'h44, 1'b0, 1'b1, n);
    check("ovf_pulse", overflow, 1);
    check("ovf_no_perr", parity_err, 0);
    tick();
    check("ovf_one_cycle", overflow, 0);
    wait_idle("ovf_frames_idle");
    check("ovf_count", ovf_cnt - n0, 1);
    check("b2b_frame_count", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_first_start", starts[0] - n1, 2);
      check("b2b_gap1", starts[1] - starts[0], 44);
      check("b2b_gap2", starts[2] - starts[1], 44);
    end

    // full buffer accepts a strobe on the stop->start pop edge
    tick();
    starts.delete();
    n0 = ovf_cnt;
    send(8'h3C, 1'b0, 1'b0, n); tick();
    send(8'h5A, 1'b0, 1'b0, n1); tick();
    send(8'h96, 1'b0, 1'b0, n1);
    goto(n + 45);
    check("popedge_done", frame_done, 1);
    send(8'hE7, 1'b0, 1'b0, n1);
    check("popedge_no_ovf", overflow, 0);
    wait_idle("popedge_idle");
    check("popedge_ovf_count", ovf_cnt - n0, 0);
    check("popedge_frames", starts.size(), 4);

    // reset mid-frame with two bytes still buffered
    tick();
    starts.delete();
    send(8'h00, 1'b0, 1'b0, n); tick();
    send(8'hF0, 1'b0, 1'b0, n1); tick();
    send(8'h81, 1'b0, 1'b0, n1);
    goto(n + 12);
    check("pre_rst_tx_low", tx_out, 0);
    #2 asyn_rst = 1'b0;
    #1;
    check("rst_mid_tx", tx_out, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", frame_done, 0);
    exp_q.delete();
    #10 asyn_rst = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_out !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    check("post_rst_quiet", low_seen, 0);
    check("post_rst_no_frames", starts.size(), 0);

    // CLKS_PER_BIT=1: 11-cycle frame
    d1 = 8'hC3;
    data1 = d1; parity1 = 1'b0; valid1 = 1'b1;
    exp1_q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) exp1_q.push_back(d1[i]);
    exp1_q.push_back(1'b0);
    exp1_q.push_back(1'b1);
    tick();
    valid1 = 1'b0;
    check("cpb1_n1_tx_high", tx1, 1);
    check("cpb1_n1_busy", busy1, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      b = exp1_q.pop_front();
      check("cpb1_bit", tx1, b);
      check("cpb1_done", done1, (i == 10) ? 1 : 0);
    end
    tick();
    check("cpb1_busy_low", busy1, 0);
    check("cpb1_tx_idle", tx1, 1);
    check("cpb1_no_ovf", ovf1, 0);
    check("cpb1_no_perr", perr1, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
